dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 10, data-memory address width; SHALL match the RAM address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  input  1  single clock, same clock as the RAM.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_req, b_req  input  1  access request from port A (CPU) or port B (secondary master).
REQ-006 a_we, b_we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 a_addr, b_addr  input  AW  access address.
REQ-008 a_wdata, b_wdata  input  DW  write data.
REQ-009 a_gnt, b_gnt  output  1  one-cycle pulse; request accepted.
REQ-010 a_rdata, b_rdata  output  DW  read data; holds until that port's next read completes.
REQ-011 a_rvalid, b_rvalid  output  1  one-cycle pulse; rdata updated.
REQ-012 mem_re, mem_we  output  1  RAM read and write strobes.
REQ-013 mem_a  output  AW  RAM address.
REQ-014 mem_di  output  DW  RAM write data.
REQ-015 mem_do  input  DW  RAM read data; valid one cycle after mem_re.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RDWAIT, with all outputs registered.
REQ-017 In IDLE, sampling any req at edge N SHALL select a winner, enter ACCESS and drive mem strobe, mem_a, mem_di and the winner's gnt during cycle N+1.
REQ-018 From ACCESS, a write SHALL return to IDLE at N+2; a read SHALL enter RDWAIT at N+2 and capture mem_do into the winner's rdata.
REQ-019 From RDWAIT, the FSM SHALL return to IDLE, with the winner's rvalid high for cycle N+3 only.
REQ-020 Write throughput SHALL be one access per 2 cycles; read throughput one per 3 cycles.
REQ-021 A requester SHALL hold req, we, addr and wdata stable until gnt; req still high in the cycle after gnt counts as a new request.
REQ-022 Requests SHALL be evaluated only in IDLE; requests arriving in ACCESS or RDWAIT wait without loss.
REQ-023 mem_re and mem_we SHALL never both be high, and SHALL be high only in ACCESS.
REQ-024 mem_a and mem_di SHALL hold their last values while the strobes are low.
REQ-025 Only one of a_gnt/b_gnt SHALL be high at a time; likewise a_rvalid/b_rvalid.
REQ-026 Address arithmetic SHALL be none; addresses pass through unmodified, including all-ones.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE and every output, rdata and mem_a included, SHALL be 0.
REQ-028 Reset mid-operation SHALL abort immediately: an in-flight read produces no rvalid, and no strobe follows reset release unless a new req is sampled.
REQ-029 Reset SHALL set the last-winner register to B, so A wins the first contention.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not served last wins, and last-winner updates on every grant.
REQ-031 DMEM_ARB_RR_EN undefined: fixed priority, A always wins contention, and the last-winner register is not implemented.

Verification
REQ-032 A write, addr 0x005, data 0xA5 -> cycle N+1: mem_we=1, mem_a=0x005, mem_di=0xA5, a_gnt=1; IDLE at N+2.
REQ-033 B read of 0x005 after REQ-032 -> mem_re=1 at N+1, b_rvalid=1 and b_rdata=0xA5 at N+3, a_rvalid stays 0.
REQ-034 Both reqs held continuously after reset -> with DMEM_ARB_RR_EN grants go A,B,A,B; without it A,A,A,A and B starves.
REQ-035 rst_n pulled low during RDWAIT of an A read -> no a_rvalid, all outputs 0, no strobe after release while reqs are low.
REQ-036 A read of 0x3FF concurrent with a B write of 0x3FF, 0x3C -> ordering per the arbitration mode; a read granted after the write returns 0x3C.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with one-cycle read latency.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]    state;
  logic          cur_b;
  logic          cur_we;
  logic          pick_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last_b;

  // On contention, serve whichever port was not served last.
  always_comb begin
    pick_b = b_req;
    if (a_req && b_req) pick_b = ~last_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_b <= 1'b1;
    else if (state == IDLE && (a_req || b_req))
      last_b <= pick_b;
  end
`else
  always_comb begin
    pick_b = b_req && !a_req;
  end
`endif

  always_comb begin
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end

  // Pulse outputs default low each cycle; mem_a/mem_di only move on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_b    <= 1'b0;
      cur_we   <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_di   <= '0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state  <= ACCESS;
            cur_b  <= pick_b;
            cur_we <= sel_we;
            a_gnt  <= ~pick_b;
            b_gnt  <= pick_b;
            mem_we <= sel_we;
            mem_re <= ~sel_we;
            mem_a  <= sel_addr;
            if (sel_we) mem_di <= sel_wdata;
          end
        end
        ACCESS: begin
          state <= cur_we ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          state <= IDLE;
          if (cur_b) begin
            b_rdata  <= mem_do;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= mem_do;
            a_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
